// File: rtl/channel_encoder.sv
// -----------------------------------------------------------------------------
// channel_encoder
// Writer side of the per-channel track store. Emits a byte-addressed write
// stream: the 4-byte directory entry, one record per track (length, artist,
// title, sample bytes, pad), and a 4-byte zero list terminator.
//
// Ports
//   Clk, Reset                 clock, asynchronous active-high reset
//   Start / Start_Block        begin session, first data block of channel
//   Track_Start / Track_Close  open / close a track record
//   Finish                     write list terminator
//   Text_Data/Valid/Ready      artist/title byte stream
//   Sample/Valid/Ready         16-bit PCM sample stream
//   Address/Data/Write         storage write request (held until accepted)
//   Write_Ready                storage accepts write on Write & Write_Ready
//   Busy                       high except in Idle and Done
//   Error                      sticky length-overflow flag
// -----------------------------------------------------------------------------
module channel_encoder #(
    parameter logic [2:0] Channel = 3'd0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [31:0] Start_Block,
    input  logic        Track_Start,
    input  logic        Track_Close,
    input  logic        Finish,
    input  logic [7:0]  Text_Data,
    input  logic        Text_Valid,
    output logic        Text_Ready,
    input  logic [15:0] Sample,
    input  logic        Sample_Valid,
    output logic        Sample_Ready,
    output logic [40:0] Address,
    output logic [7:0]  Data,
    output logic        Write,
    input  logic        Write_Ready,
    output logic        Busy,
    output logic        Error
);

    localparam logic [40:0] DIR_ADDR = {36'd0, Channel, 2'd0};
    localparam logic [31:0] LEN_MAX  = 32'hFFFF_FFFF;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WRITE_DIR,
        S_READY,
        S_WRITE_ARTIST,
        S_WRITE_TITLE,
        S_WRITE_SOUND,
        S_WRITE_PAD,
        S_PATCH_LEN,
        S_WRITE_TERM,
        S_DONE
    } state_t;

    state_t      state_q;
    logic [40:0] cursor_q;
    logic [40:0] hdr_q;
    logic [31:0] len_q;
    logic [31:0] blk_q;
    logic [40:0] addr_q;
    logic [7:0]  data_q;
    logic        write_q;
    logic        err_q;
    logic [1:0]  cnt_q;
    logic [7:0]  hi_q;
    logic        phase_q;
    logic        zero_q;
    logic        close_q;

    logic        accepted;
    logic        len_sat_d;
    logic [31:0] len_inc_d;

    // Byte lane i (little-endian) of a 32-bit word.
    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] i);
        logic [7:0] b;
        case (i)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

    assign accepted  = write_q & Write_Ready;
    // L saturates rather than wrapping; saturation raises Error.
    assign len_sat_d = (len_q == LEN_MAX);
    assign len_inc_d = len_sat_d ? len_q : len_q + 32'd1;

    assign Address      = addr_q;
    assign Data         = data_q;
    assign Write        = write_q;
    assign Error        = err_q;
    assign Busy         = (state_q != S_IDLE) && (state_q != S_DONE);
    assign Text_Ready   = !write_q && ((state_q == S_WRITE_ARTIST) || (state_q == S_WRITE_TITLE));
    assign Sample_Ready = !write_q && (state_q == S_WRITE_SOUND);

    // Single-process control FSM; every write request is issued from here.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            cursor_q <= 41'd0;
            hdr_q    <= 41'd0;
            len_q    <= 32'd0;
            blk_q    <= 32'd0;
            addr_q   <= 41'd0;
            data_q   <= 8'd0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= 2'd0;
            hi_q     <= 8'd0;
            phase_q  <= 1'b0;
            zero_q   <= 1'b0;
            close_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (Start) begin
                        blk_q   <= Start_Block;
                        addr_q  <= DIR_ADDR;
                        data_q  <= Start_Block[7:0];
                        write_q <= 1'b1;
                        cnt_q   <= 2'd0;
                        state_q <= S_WRITE_DIR;
                    end
                end

                S_WRITE_DIR: begin
                    if (accepted) begin
                        if (cnt_q == 2'd3) begin
                            write_q  <= 1'b0;
                            cursor_q <= {blk_q, 9'd0};
                            state_q  <= S_READY;
                        end else begin
                            cnt_q  <= cnt_q + 2'd1;
                            addr_q <= DIR_ADDR + 41'(cnt_q) + 41'd1;
                            data_q <= byte_of(blk_q, cnt_q + 2'd1);
                        end
                    end
                end

                S_READY: begin
                    if (Track_Start) begin
                        hdr_q    <= cursor_q;
                        cursor_q <= cursor_q + 41'd4;
                        len_q    <= 32'd0;
                        close_q  <= 1'b0;
                        state_q  <= S_WRITE_ARTIST;
                    end else if (Finish) begin
                        addr_q   <= cursor_q;
                        data_q   <= 8'd0;
                        write_q  <= 1'b1;
                        cursor_q <= cursor_q + 41'd1;
                        cnt_q    <= 2'd0;
                        state_q  <= S_WRITE_TERM;
                    end
                end

                S_WRITE_ARTIST, S_WRITE_TITLE: begin
                    if (accepted) begin
                        write_q <= 1'b0;
                        // The terminating 0x00 of a string ends that field.
                        if (zero_q) begin
                            state_q <= (state_q == S_WRITE_ARTIST) ? S_WRITE_TITLE : S_WRITE_SOUND;
                        end
                    end else if (!write_q && Text_Valid) begin
                        addr_q   <= cursor_q;
                        data_q   <= Text_Data;
                        write_q  <= 1'b1;
                        zero_q   <= (Text_Data == 8'd0);
                        cursor_q <= cursor_q + 41'd1;
                        len_q    <= len_inc_d;
                        if (len_sat_d) err_q <= 1'b1;
                    end
                end

                S_WRITE_SOUND: begin
                    if (write_q) begin
                        // A close during a sample is deferred to the end of the sample.
                        if (Track_Close) close_q <= 1'b1;
                        if (accepted) begin
                            if (!phase_q) begin
                                addr_q   <= cursor_q;
                                data_q   <= hi_q;
                                phase_q  <= 1'b1;
                                cursor_q <= cursor_q + 41'd1;
                                len_q    <= len_inc_d;
                                if (len_sat_d) err_q <= 1'b1;
                            end else if (close_q || Track_Close) begin
                                close_q  <= 1'b0;
                                addr_q   <= cursor_q;
                                data_q   <= 8'd0;
                                cursor_q <= cursor_q + 41'd1;
                                len_q    <= len_inc_d;
                                if (len_sat_d) err_q <= 1'b1;
                                state_q  <= S_WRITE_PAD;
                            end else begin
                                write_q <= 1'b0;
                            end
                        end
                    end else if (Sample_Valid) begin
                        addr_q   <= cursor_q;
                        data_q   <= Sample[7:0];
                        hi_q     <= Sample[15:8];
                        write_q  <= 1'b1;
                        phase_q  <= 1'b0;
                        close_q  <= Track_Close;
                        cursor_q <= cursor_q + 41'd1;
                        len_q    <= len_inc_d;
                        if (len_sat_d) err_q <= 1'b1;
                    end else if (Track_Close) begin
                        addr_q   <= cursor_q;
                        data_q   <= 8'd0;
                        write_q  <= 1'b1;
                        cursor_q <= cursor_q + 41'd1;
                        len_q    <= len_inc_d;
                        if (len_sat_d) err_q <= 1'b1;
                        state_q  <= S_WRITE_PAD;
                    end
                end

                S_WRITE_PAD: begin
                    // Pad accepted: L is now final, start patching the header.
                    if (accepted) begin
                        addr_q  <= hdr_q;
                        data_q  <= len_q[7:0];
                        cnt_q   <= 2'd0;
                        state_q <= S_PATCH_LEN;
                    end
                end

                S_PATCH_LEN: begin
                    if (accepted) begin
                        if (cnt_q == 2'd3) begin
                            write_q <= 1'b0;
                            state_q <= S_READY;
                        end else begin
                            cnt_q  <= cnt_q + 2'd1;
                            addr_q <= hdr_q + 41'(cnt_q) + 41'd1;
                            data_q <= byte_of(len_q, cnt_q + 2'd1);
                        end
                    end
                end

                S_WRITE_TERM: begin
                    if (accepted) begin
                        if (cnt_q == 2'd3) begin
                            write_q <= 1'b0;
                            state_q <= S_DONE;
                        end else begin
                            cnt_q    <= cnt_q + 2'd1;
                            addr_q   <= cursor_q;
                            cursor_q <= cursor_q + 41'd1;
                        end
                    end
                end

                S_DONE: begin
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_channel_encoder.sv
// -----------------------------------------------------------------------------
// tb_channel_encoder
// Directed bench for channel_encoder (Channel = 2). Logs every accepted storage
// write and compares against hand-computed addresses and bytes.
// -----------------------------------------------------------------------------
module tb_channel_encoder;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [31:0] Start_Block;
    logic        Track_Start;
    logic        Track_Close;
    logic        Finish;
    logic [7:0]  Text_Data;
    logic        Text_Valid;
    logic        Text_Ready;
    logic [15:0] Sample;
    logic        Sample_Valid;
    logic        Sample_Ready;
    logic [40:0] Address;
    logic [7:0]  Data;
    logic        Write;
    logic        Write_Ready;
    logic        Busy;
    logic        Error;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [40:0] log_a[$];
    logic [7:0]  log_d[$];

    channel_encoder #(.Channel(3'd2)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Start        (Start),
        .Start_Block  (Start_Block),
        .Track_Start  (Track_Start),
        .Track_Close  (Track_Close),
        .Finish       (Finish),
        .Text_Data    (Text_Data),
        .Text_Valid   (Text_Valid),
        .Text_Ready   (Text_Ready),
        .Sample       (Sample),
        .Sample_Valid (Sample_Valid),
        .Sample_Ready (Sample_Ready),
        .Address      (Address),
        .Data         (Data),
        .Write        (Write),
        .Write_Ready  (Write_Ready),
        .Busy         (Busy),
        .Error        (Error)
    );

    always #5 Clk = ~Clk;

    // Storage-side log of accepted writes.
    always @(posedge Clk) begin
        if (Write && Write_Ready) begin
            log_a.push_back(Address);
            log_d.push_back(Data);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_write(input int idx, input logic [40:0] a, input logic [7:0] d);
        logic [40:0] oa;
        logic [7:0]  od;
        oa = (idx < log_a.size()) ? log_a[idx] : '1;
        od = (idx < log_d.size()) ? log_d[idx] : 8'hxx;
        check($sformatf("wr%0d_addr", idx), 64'(oa), 64'(a));
        check($sformatf("wr%0d_data", idx), 64'(od), 64'(d));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_addr"}, 64'(Address), 64'd0);
        check({tag, "_data"}, 64'(Data), 64'd0);
        check({tag, "_ctl"}, 64'({Write, Busy, Error, Text_Ready, Sample_Ready}), 64'd0);
    endtask

    task automatic wait_writes(input int n);
        int k = 0;
        while (log_a.size() < n && k < 300) begin
            @(negedge Clk);
            k++;
        end
        check($sformatf("write_count_%0d", n), 64'(log_a.size()), 64'(n));
    endtask

    task automatic send_text(input logic [7:0] b);
        int k = 0;
        while (!Text_Ready && k < 100) begin
            @(negedge Clk);
            k++;
        end
        if (!Text_Ready) check("text_ready_timeout", 64'(Text_Ready), 64'd1);
        Text_Data  = b;
        Text_Valid = 1'b1;
        @(negedge Clk);
        Text_Valid = 1'b0;
    endtask

    task automatic send_sample(input logic [15:0] s);
        int k = 0;
        while (!Sample_Ready && k < 100) begin
            @(negedge Clk);
            k++;
        end
        if (!Sample_Ready) check("sample_ready_timeout", 64'(Sample_Ready), 64'd1);
        Sample       = s;
        Sample_Valid = 1'b1;
        @(negedge Clk);
        Sample_Valid = 1'b0;
    endtask

    initial begin
        logic [7:0] body1 [10];
        logic [7:0] body2 [9];
        logic [40:0] addr2 [9];

        body1 = '{8'h41, 8'h42, 8'h00, 8'h43, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h00};
        body2 = '{8'h00, 8'h00, 8'h66, 8'h55, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
        addr2 = '{41'h2012, 41'h2013, 41'h2014, 41'h2015, 41'h2016,
                  41'h200E, 41'h200F, 41'h2010, 41'h2011};

        Reset = 1'b1; Start = 1'b0; Start_Block = 32'd0; Track_Start = 1'b0;
        Track_Close = 1'b0; Finish = 1'b0; Text_Data = 8'd0; Text_Valid = 1'b0;
        Sample = 16'd0; Sample_Valid = 1'b0; Write_Ready = 1'b1;

        repeat (2) @(negedge Clk);
        check_outputs_zero("reset");
        Reset = 1'b0;
        @(negedge Clk);

        // Directory entry for Channel 2, Start_Block 0x10.
        Start_Block = 32'h10; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        check("busy_after_start", 64'(Busy), 64'd1);
        wait_writes(4);
        check_write(0, 41'h8, 8'h10);
        check_write(1, 41'h9, 8'h00);
        check_write(2, 41'hA, 8'h00);
        check_write(3, 41'hB, 8'h00);

        // Track 1: "AB", "C", two samples, close between samples.
        Track_Start = 1'b1;
        @(negedge Clk);
        Track_Start = 1'b0;
        send_text(8'h41); send_text(8'h42); send_text(8'h00);
        send_text(8'h43); send_text(8'h00);
        send_sample(16'h1234); send_sample(16'hABCD);
        wait_writes(13);
        Track_Close = 1'b1;
        @(negedge Clk);
        Track_Close = 1'b0;
        wait_writes(18);
        for (int i = 0; i < 10; i++) check_write(4 + i, 41'h2004 + 41'(i), body1[i]);
        check_write(14, 41'h2000, 8'h0A);
        check_write(15, 41'h2001, 8'h00);
        check_write(16, 41'h2002, 8'h00);
        check_write(17, 41'h2003, 8'h00);

        // Track_Close in Ready is ignored.
        Track_Close = 1'b1;
        @(negedge Clk);
        Track_Close = 1'b0;
        repeat (3) @(negedge Clk);
        check("ready_close_no_write", 64'(log_a.size()), 64'd18);
        check("ready_close_busy", 64'({Busy, Write}), 64'b10);

        // Track 2: empty strings, one stalled sample, close on low-byte acceptance.
        Track_Start = 1'b1;
        @(negedge Clk);
        Track_Start = 1'b0;
        send_text(8'h00); send_text(8'h00);
        wait_writes(20);
        Write_Ready = 1'b0;
        send_sample(16'h5566);
        for (int i = 0; i < 5; i++) begin
            check("stall_write", 64'(Write), 64'd1);
            check("stall_addr", 64'(Address), 64'h2014);
            check("stall_data", 64'(Data), 64'h66);
            check("stall_sready", 64'(Sample_Ready), 64'd0);
            @(negedge Clk);
        end
        check("stall_no_write", 64'(log_a.size()), 64'd20);
        Write_Ready = 1'b1;
        Track_Close = 1'b1;
        @(negedge Clk);
        Track_Close = 1'b0;
        wait_writes(27);
        for (int i = 0; i < 9; i++) check_write(18 + i, addr2[i], body2[i]);

        // Terminator.
        Finish = 1'b1;
        @(negedge Clk);
        Finish = 1'b0;
        wait_writes(31);
        for (int i = 0; i < 4; i++) check_write(27 + i, 41'h2017 + 41'(i), 8'h00);
        repeat (2) @(negedge Clk);
        check("done_ctl", 64'({Busy, Write, Error}), 64'd0);
        check("done_no_more_writes", 64'(log_a.size()), 64'd31);

        // New session after reset; reset asserted during PatchLen.
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        log_a.delete(); log_d.delete();
        @(negedge Clk);
        Start_Block = 32'h20; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        Track_Start = 1'b1;
        repeat (6) @(negedge Clk);
        Track_Start = 1'b0;
        wait_writes(4);
        send_text(8'h00); send_text(8'h00);
        wait_writes(6);
        Track_Close = 1'b1;
        @(negedge Clk);
        Track_Close = 1'b0;
        wait_writes(7);
        check_write(6, 41'h4006, 8'h00);
        Write_Ready = 1'b0;
        check("patch_addr", 64'(Address), 64'h4000);
        check("patch_len0", 64'(Data), 64'h03);
        check("patch_write", 64'(Write), 64'd1);
        #2 Reset = 1'b1;
        #1 check_outputs_zero("async_reset");
        @(negedge Clk);
        Reset = 1'b0;
        Write_Ready = 1'b1;
        log_a.delete(); log_d.delete();
        @(negedge Clk);
        Start_Block = 32'h30; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        wait_writes(4);
        check_write(0, 41'h8, 8'h30);
        check_write(3, 41'hB, 8'h00);
        check("restart_busy", 64'(Busy), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
